// File: rtl/block_scan_read_ctrl_if.sv
// AXI read address/data channel bundle between the block scan reader and memory.
interface block_scan_read_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic                  arvalid;
  logic                  arready;
  logic                  rvalid;
  logic                  rlast;
  logic                  rready;

  modport master (
    output araddr, arlen, arvalid, rready,
    input  arready, rvalid, rlast
  );

  modport slave (
    input  araddr, arlen, arvalid, rready,
    output arready, rvalid, rlast
  );
endinterface

// File: rtl/block_scan_read_ctrl.sv
// Queues frame base addresses and scans each frame as BLOCK_SIZE x BLOCK_SIZE tiles,
// issuing one AXI read burst per tile row with an outstanding-burst limit.
module block_scan_read_ctrl #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned BLOCK_SIZE      = 8,
  parameter int unsigned BYTES_PER_PIXEL = 4,
  parameter int unsigned FRAME_Q_DEPTH   = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            frame_width,
  input  logic [15:0]            frame_height,
  input  logic                   enable,
  input  logic                   frame_ready,
  input  logic [ADDR_WIDTH-1:0]  base_addr_in,
  block_scan_read_ctrl_if.master axi,
  input  logic                   consumer_ready,
  output logic                   start_of_frame,
  output logic                   start_of_block,
  output logic                   end_of_frame,
  output logic [ADDR_WIDTH-1:0]  base_addr_out,
  output logic [31:0]            block_count,
  output logic                   busy,
  output logic                   q_overflow,
  output logic                   protocol_err
);
  localparam int unsigned LogBs  = $clog2(BLOCK_SIZE);
  localparam int unsigned LogBpp = $clog2(BYTES_PER_PIXEL);
  localparam int unsigned PtrW   = (FRAME_Q_DEPTH > 1) ? $clog2(FRAME_Q_DEPTH) : 1;
  localparam int unsigned CntW   = $clog2(FRAME_Q_DEPTH + 1);
  localparam logic [PtrW-1:0]       PtrLast  = PtrW'(FRAME_Q_DEPTH - 1);
  localparam logic [CntW-1:0]       QFull    = CntW'(FRAME_Q_DEPTH);
  localparam logic [3:0]            MaxOut   = 4'(MAX_OUTSTANDING);
  localparam logic [5:0]            RowLast  = 6'(BLOCK_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] TileStep = ADDR_WIDTH'(BLOCK_SIZE * BYTES_PER_PIXEL);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                state;
  logic [ADDR_WIDTH-1:0] q_mem [FRAME_Q_DEPTH];
  logic [PtrW-1:0]       rd_ptr, wr_ptr;
  logic [CntW-1:0]       q_cnt;
  logic [3:0]            outstanding, out_next;
  logic [15:0]           bx, by, bx_last, by_last, new_bx, new_by;
  logic [5:0]            row;
  logic [ADDR_WIDTH-1:0] line_stride, tile_row_stride, new_line_stride;
  logic [ADDR_WIDTH-1:0] araddr_q, tile_addr, tile_row_addr;
  logic [7:0]            arlen_q;
  logic                  arvalid_q, first_ar, zero_sof;
  logic                  q_empty, q_full, start_frame, q_push, ar_hs, r_done, r_err, last_ar;

  always_comb begin
    new_bx          = frame_width >> LogBs;
    new_by          = frame_height >> LogBs;
    new_line_stride = ADDR_WIDTH'(frame_width) << LogBpp;
    q_empty         = (q_cnt == '0);
    q_full          = (q_cnt == QFull);
    start_frame     = (state == StIdle) && !q_empty && enable;
    // A pop in the same cycle frees the slot a push to a full queue needs.
    q_push          = frame_ready && (!q_full || start_frame);
    ar_hs           = arvalid_q && axi.arready;
    r_done          = axi.rvalid && axi.rready && axi.rlast;
    r_err           = r_done && !ar_hs && (outstanding == '0);
    out_next        = outstanding;
    if (ar_hs && !r_done) begin
      out_next = outstanding + 4'd1;
    end else if (r_done && !ar_hs && (outstanding != '0)) begin
      out_next = outstanding - 4'd1;
    end
    last_ar = ar_hs && (row == RowLast) && (bx == bx_last) && (by == by_last);
  end

  always_ff @(posedge clk) begin
    if (q_push) begin
      q_mem[wr_ptr] <= base_addr_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= StIdle;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      q_cnt           <= '0;
      outstanding     <= '0;
      bx              <= '0;
      by              <= '0;
      bx_last         <= '0;
      by_last         <= '0;
      row             <= '0;
      line_stride     <= '0;
      tile_row_stride <= '0;
      araddr_q        <= '0;
      tile_addr       <= '0;
      tile_row_addr   <= '0;
      arlen_q         <= '0;
      arvalid_q       <= 1'b0;
      first_ar        <= 1'b0;
      zero_sof        <= 1'b0;
      end_of_frame    <= 1'b0;
      base_addr_out   <= '0;
      block_count     <= '0;
      q_overflow      <= 1'b0;
      protocol_err    <= 1'b0;
    end else begin
      arlen_q      <= 8'(BLOCK_SIZE - 1);
      zero_sof     <= 1'b0;
      end_of_frame <= 1'b0;
      outstanding  <= out_next;
      if (r_err) protocol_err <= 1'b1;
      if (frame_ready && !q_push) q_overflow <= 1'b1;

      if (q_push) wr_ptr <= (wr_ptr == PtrLast) ? '0 : wr_ptr + 1'b1;
      if (start_frame) rd_ptr <= (rd_ptr == PtrLast) ? '0 : rd_ptr + 1'b1;
      if (q_push && !start_frame) begin
        q_cnt <= q_cnt + 1'b1;
      end else if (!q_push && start_frame) begin
        q_cnt <= q_cnt - 1'b1;
      end

      unique case (state)
        StIdle: begin
          if (start_frame) begin
            base_addr_out <= q_mem[rd_ptr];
            block_count   <= '0;
            if ((new_bx == '0) || (new_by == '0)) begin
              state        <= StDone;
              zero_sof     <= 1'b1;
              end_of_frame <= 1'b1;
            end else begin
              state           <= StIssue;
              bx_last         <= new_bx - 16'd1;
              by_last         <= new_by - 16'd1;
              line_stride     <= new_line_stride;
              tile_row_stride <= new_line_stride << LogBs;
              bx              <= '0;
              by              <= '0;
              row             <= '0;
              araddr_q        <= q_mem[rd_ptr];
              tile_addr       <= q_mem[rd_ptr];
              tile_row_addr   <= q_mem[rd_ptr];
              first_ar        <= 1'b1;
              arvalid_q       <= (out_next < MaxOut);
            end
          end
        end
        StIssue: begin
          // Once raised, arvalid cannot drop: out_next only falls until the handshake.
          arvalid_q <= !last_ar && (out_next < MaxOut);
          if (ar_hs) begin
            first_ar <= 1'b0;
            if (row == '0) block_count <= block_count + 32'd1;
            if (last_ar) state <= StDrain;
            if (row != RowLast) begin
              row      <= row + 6'd1;
              araddr_q <= araddr_q + line_stride;
            end else begin
              row <= '0;
              if (bx != bx_last) begin
                bx        <= bx + 16'd1;
                tile_addr <= tile_addr + TileStep;
                araddr_q  <= tile_addr + TileStep;
              end else begin
                bx            <= '0;
                by            <= by + 16'd1;
                tile_row_addr <= tile_row_addr + tile_row_stride;
                tile_addr     <= tile_row_addr + tile_row_stride;
                araddr_q      <= tile_row_addr + tile_row_stride;
              end
            end
          end
        end
        StDrain: begin
          if (outstanding == '0) begin
            state        <= StDone;
            end_of_frame <= 1'b1;
          end
        end
        StDone: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  assign axi.araddr     = araddr_q;
  assign axi.arlen      = arlen_q;
  assign axi.arvalid    = arvalid_q;
  assign axi.rready     = consumer_ready;
  assign start_of_block = ar_hs && (row == '0);
  assign start_of_frame = (ar_hs && first_ar) || zero_sof;
  assign busy           = (state != StIdle);

endmodule

// File: doc/block_scan_read_ctrl.md
Name: block_scan_read_ctrl

Overview:
- Parametrised, multi-frame successor to the per-filter memory readers (noise estimation / Wiener).
- Accepts completed frame base addresses from memory_writer into a frame queue.
- For each frame, issues AXI read address bursts that scan BLOCK_SIZE x BLOCK_SIZE tiles in block-raster order, one burst per tile row. Tracks outstanding bursts against a configurable limit.
- Emits frame and block framing pulses for the downstream statistics/filter datapath. Drives one AXI_memory_master read channel directly.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- BLOCK_SIZE, 8, tile edge in pixels; power of 2, range 2..64.
- BYTES_PER_PIXEL, 4, bytes per pixel word; power of 2.
- FRAME_Q_DEPTH, 2, frame base address queue depth; at least 1.
- MAX_OUTSTANDING, 4, maximum AR bursts accepted but not yet completed by rlast; range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- frame_width  in  16  pixels per line; sampled at frame start.
- frame_height  in  16  lines per frame; sampled at frame start.
- enable  in  1  permits starting a new frame; does not stop a frame in progress.
- frame_ready  in  1  one-cycle pulse; pushes base_addr_in into the queue.
- base_addr_in  in  ADDR_WIDTH  frame base byte address.
- araddr  out  ADDR_WIDTH  burst start address.
- arlen  out  8  constant BLOCK_SIZE-1.
- arvalid  out  1  address valid.
- arready  in  1  address accept.
- rvalid  in  1  read data valid.
- rlast  in  1  last beat of burst.
- rready  out  1  data accept.
- consumer_ready  in  1  downstream can take a beat; rready = consumer_ready.
- start_of_frame  out  1  pulse on the first AR of a frame.
- start_of_block  out  1  pulse on the first AR of each tile.
- end_of_frame  out  1  pulse once all bursts of the frame have completed.
- base_addr_out  out  ADDR_WIDTH  base address of the current/last frame.
- block_count  out  32  tiles issued in the current frame.
- busy  out  1  high when state is not IDLE.
- q_overflow  out  1  sticky; a push was dropped.
- protocol_err  out  1  sticky; rlast arrived with no burst outstanding.

Behaviour:
- Reset (asynchronous) clears:
  - all outputs to 0;
  - the queue to empty;
  - all counters to 0;
  - state to IDLE.
- Reset mid-frame abandons the frame. No end_of_frame is generated.
- Derived geometry, sampled at frame start:
  - blocks_x = frame_width >> log2(BLOCK_SIZE); blocks_y likewise from frame_height.
  - Remainder pixels are never read.
  - line_stride = frame_width * BYTES_PER_PIXEL, implemented as a shift.
  - tile_row_stride = line_stride * BLOCK_SIZE, implemented as a shift.
- Burst address for tile (bx, by), row r:
  - base + ((by*BLOCK_SIZE + r) * frame_width + bx*BLOCK_SIZE) * BYTES_PER_PIXEL.
  - Generated incrementally with adders only; no multipliers.
  - Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Frame queue (FIFO):
  - A push while full is dropped and sets q_overflow, unless a pop occurs in the same cycle, in which case the push is accepted.
  - A push to an empty queue in the same cycle as IDLE evaluation takes effect next cycle.
- State machine:
  - IDLE -> ISSUE when the queue is non-empty and enable=1, and blocks_x>0 and blocks_y>0. On this transition: pop the queue, latch geometry, load base_addr_out.
  - IDLE -> DONE when the queue is non-empty, enable=1, and either dimension is zero. Pop the queue. No AR is issued. start_of_frame and end_of_frame pulse in the same cycle.
  - ISSUE: arvalid=1 when outstanding < MAX_OUTSTANDING.
    - araddr and arvalid are held stable until arready.
    - On handshake, advance r, then bx, then by.
    - start_of_block and start_of_frame are asserted in the handshake cycle.
    - block_count increments on each tile's first handshake.
    - After the last handshake (bx=blocks_x-1, by=blocks_y-1, r=BLOCK_SIZE-1), go to DRAIN.
  - DRAIN -> DONE when outstanding == 0.
  - DONE: end_of_frame pulses for one cycle, then IDLE.
- Bursts per frame = blocks_x * blocks_y * BLOCK_SIZE.
- Outstanding counter:
  - +1 on arvalid&arready.
  - -1 on rvalid&rready&rlast.
  - Both in the same cycle: unchanged.
  - A decrement at 0 saturates at 0 and sets protocol_err.
- Latency: arvalid rises 1 cycle after the IDLE->ISSUE decision; back-to-back bursts issue every cycle while arready=1 and the outstanding limit is not reached.

Test Plan:
- 16x16 frame, base 0x1000, BPP=4, BLOCK_SIZE=8, arready=1, responses returned promptly -> 32 bursts, arlen=7 each.
  - Address sequence: 0x1000, 0x1040, ... 0x11C0, then 0x1020..., then 0x1200...
  - 4 start_of_block pulses; block_count=4; end_of_frame after the 32nd rlast.
- arready held low 5 cycles on the first burst -> araddr stays at 0x1000 and arvalid stays high; no pulses until the handshake cycle.
- MAX_OUTSTANDING=2, rvalid withheld -> exactly 2 AR handshakes, then arvalid=0.
  - One rlast -> exactly one more burst issued.
- 20x9 frame -> blocks_x=2, blocks_y=1, 16 bursts; remainder pixels never addressed.
- Three frame_ready pulses with FRAME_Q_DEPTH=2 while busy -> q_overflow=1.
  - The two queued frames are processed in order; base_addr_out matches each.
- Assert rst mid-ISSUE -> all outputs 0 next cycle; a late rlast sets protocol_err; the next frame runs cleanly from its base address.
